// File: rtl/llc_dma_req_gen_pkg.sv
// Shared types and constants for the LLC DMA request generator.
package llc_dma_req_gen_pkg;

    // Width of an LLC line address and of a cache line payload.
    localparam int LINE_ADDR_BITS = 16;
    localparam int LINE_BITS      = 32;

    // Coherence message codes carried on the LLC DMA request channel.
    localparam logic [1:0] DMA_REQ_READ  = 2'b01;
    localparam logic [1:0] DMA_REQ_WRITE = 2'b10;

    // Transfer sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } dma_gen_state_t;

    // Coherence message for a transfer direction.
    function automatic logic [1:0] dma_coh_msg(input logic is_write);
        return is_write ? DMA_REQ_WRITE : DMA_REQ_READ;
    endfunction

endpackage

// File: rtl/llc_dma_rsp_buf.sv
// One-entry valid/ready register slice. Accepts a new entry when empty or
// when the current entry leaves in the same cycle; flush discards the entry.
module llc_dma_rsp_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    // Entry register: load, drain or flush; data holds while stalled.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/llc_dma_req_gen.sv
// LLC DMA request generator: turns a line-granular transfer descriptor into
// one LLC DMA request per line and returns read lines in order.
// Optional watchdog: define LLC_DMA_REQ_GEN_TIMEOUT_EN.
module llc_dma_req_gen
    import llc_dma_req_gen_pkg::*;
#(
    parameter int LEN_BITS        = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      desc_valid,
    output logic                      desc_ready,
    input  logic                      desc_write,
    input  logic [LINE_ADDR_BITS-1:0] desc_addr,
    input  logic [LEN_BITS-1:0]       desc_len,
    input  logic                      wdata_valid,
    output logic                      wdata_ready,
    input  logic [LINE_BITS-1:0]      wdata_line,
    output logic                      req_valid,
    input  logic                      req_ready,
    output logic [1:0]                req_coh_msg,
    output logic [LINE_ADDR_BITS-1:0] req_addr,
    output logic [LINE_BITS-1:0]      req_line,
    input  logic                      rsp_valid,
    output logic                      rsp_ready,
    input  logic [LINE_BITS-1:0]      rsp_line,
    output logic                      rdata_valid,
    input  logic                      rdata_ready,
    output logic [LINE_BITS-1:0]      rdata_line,
    output logic                      busy,
    output logic                      done,
    output logic                      error
);

    localparam int REQ_W = 2 + LINE_ADDR_BITS + LINE_BITS;
    localparam int OUT_W = 4;
    localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("llc_dma_req_gen: MAX_OUTSTANDING must be 1..15 and TIMEOUT_CYCLES >= 1");
    end

    dma_gen_state_t state_q, state_next;

    logic [LINE_ADDR_BITS-1:0] addr_q;
    logic [LEN_BITS-1:0]       len_q;
    logic                      write_q;
    logic [LEN_BITS-1:0]       load_cnt_q;
    logic [LEN_BITS-1:0]       issued_q;
    logic [LEN_BITS-1:0]       issued_inc;
    logic [OUT_W-1:0]          outstanding_q;
    logic [OUT_W-1:0]          out_next;

    logic             desc_hs, req_hs, rsp_hs, rd_inc, issue_last;
    logic             is_issue, ld_more, rd_load, wr_load;
    logic             req_in_valid, req_in_ready;
    logic [REQ_W-1:0] req_in_data, req_out_data;
    logic             rsp_in_valid, rsp_in_ready;
    logic             timeout_hit;

    assign desc_hs    = desc_valid && desc_ready;
    assign req_hs     = req_valid && req_ready;
    assign rsp_hs     = rsp_valid && rsp_ready;
    assign rd_inc     = req_hs && (req_coh_msg == DMA_REQ_READ);
    assign issued_inc = issued_q + 1'b1;
    assign issue_last = req_hs && (issued_inc == len_q);
    assign is_issue   = (state_q == ISSUE);
    assign ld_more    = (load_cnt_q != len_q);

    // Outstanding reads after this cycle: issue and answer together cancel,
    // and an answer with nothing outstanding leaves the count at zero.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        out_next = outstanding_q;
        if (rd_inc && !rsp_hs) begin
            out_next = outstanding_q + 1'b1;
        end else if (!rd_inc && rsp_hs && (outstanding_q != '0)) begin
            out_next = outstanding_q - 1'b1;
        end
    end

    // A read is staged only if it still fits under the outstanding limit once
    // this cycle's issue/answer are accounted for.
    assign rd_load      = is_issue && !write_q && ld_more && req_in_ready && (out_next < MAX_OUT);
    assign wdata_ready  = is_issue && write_q && ld_more && req_in_ready;
    assign wr_load      = wdata_ready && wdata_valid;
    assign req_in_valid = rd_load || wr_load;
    assign req_in_data  = {dma_coh_msg(write_q), addr_q, write_q ? wdata_line : {LINE_BITS{1'b0}}};

    llc_dma_rsp_buf #(
        .WIDTH (REQ_W)
    ) u_req_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (timeout_hit),
        .in_valid  (req_in_valid),
        .in_ready  (req_in_ready),
        .in_data   (req_in_data),
        .out_valid (req_valid),
        .out_ready (req_ready),
        .out_data  (req_out_data)
    );

    assign {req_coh_msg, req_addr, req_line} = req_out_data;

    // Responses are taken in every state but IDLE; stray ones are dropped.
    assign rsp_ready    = (state_q != IDLE) && rsp_in_ready;
    assign rsp_in_valid = rsp_valid && (state_q != IDLE) && (outstanding_q != '0);

    llc_dma_rsp_buf #(
        .WIDTH (LINE_BITS)
    ) u_rsp_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (timeout_hit),
        .in_valid  (rsp_in_valid),
        .in_ready  (rsp_in_ready),
        .in_data   (rsp_line),
        .out_valid (rdata_valid),
        .out_ready (rdata_ready),
        .out_data  (rdata_line)
    );

`ifdef LLC_DMA_REQ_GEN_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_q;
    logic            error_q;
    logic            stalled;

    assign stalled     = (state_q == DRAIN) || (is_issue && req_valid && !req_ready);
    assign timeout_hit = stalled && !req_hs && !rsp_hs && (to_cnt_q == TO_LAST);
    assign error       = error_q;

    // Watchdog: counts stalled cycles, restarts on any channel progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_q <= '0;
            error_q  <= 1'b0;
        end else begin
            if (timeout_hit) begin
                error_q <= 1'b1;
            end
            if (req_hs || rsp_hs || timeout_hit || (state_q == IDLE)) begin
                to_cnt_q <= '0;
            end else if (stalled) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign error       = 1'b0;
`endif

    // Next-state selection; a watchdog expiry forces completion.
    always_comb begin
        state_next = state_q;
        case (state_q)
            IDLE:    if (desc_hs) state_next = (desc_len == '0) ? DONE : ISSUE;
            ISSUE:   if (issue_last) state_next = write_q ? DONE : DRAIN;
            DRAIN:   if ((outstanding_q == '0) && !rdata_valid) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (timeout_hit) begin
            state_next = DONE;
        end
    end

    // State register with status outputs registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            desc_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_next;
            desc_ready <= (state_next == IDLE);
            busy       <= (state_next != IDLE);
            done       <= (state_next == DONE);
        end
    end

    // Descriptor latch, address walk and issue/outstanding bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q        <= '0;
            len_q         <= '0;
            write_q       <= 1'b0;
            load_cnt_q    <= '0;
            issued_q      <= '0;
            outstanding_q <= '0;
        end else begin
            if (desc_hs) begin
                addr_q     <= desc_addr;
                len_q      <= desc_len;
                write_q    <= desc_write;
                load_cnt_q <= '0;
                issued_q   <= '0;
            end else begin
                if (req_in_valid) begin
                    addr_q     <= addr_q + 1'b1;
                    load_cnt_q <= load_cnt_q + 1'b1;
                end
                if (req_hs) begin
                    issued_q <= issued_inc;
                end
            end
            outstanding_q <= timeout_hit ? '0 : out_next;
        end
    end

endmodule
